// File: rtl/msx_cas_pkg.sv
// Shared types and default timing constants for the MSX cassette FSK player.
package msx_cas_pkg;

   typedef enum logic [2:0] {IDLE, LEADER, START, DATA, STOP} cas_state_t;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      SHORT = 2'b01,
      LONG  = 2'b10
   } cas_leader_t;

   localparam int CAS_HALF_0 = 1491;
   localparam int CAS_HALF_1 = 746;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] leader;
   } cas_req_t;

endpackage

// File: rtl/cas_tone_gen.sv
// Half-period tick counter and square-wave level for the FSK player.
module cas_tone_gen (
   input  logic        clk21m,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        run,
   input  logic        active,
   input  logic        start,
   input  logic [10:0] half_len,
   output logic        level,
   output logic        half_done
);

   logic [10:0] cnt;
   logic        last;

   assign last      = cnt == (half_len - 11'd1);
   assign half_done = tick & run & active & last;

   // start wins over !active so the first half begins at level 1 out of IDLE
   always_ff @(posedge clk21m) begin
      if (!reset_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (start) begin
         cnt   <= '0;
         level <= 1'b1;
      end else if (!active) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (tick & run) begin
         if (last) begin
            cnt   <= '0;
            level <= ~level;
         end else begin
            cnt <= cnt + 11'd1;
         end
      end
   end

endmodule

// File: rtl/cas_fsk_player.sv
// MSX 1200-baud cassette FSK transmitter with optional 2400 Hz leader.
// Define CAS_TURBO_EN to add the 'turbo' port (halved half-periods, 2400 baud).
module cas_fsk_player
   import msx_cas_pkg::*;
#(
   parameter int HALF_0       = CAS_HALF_0,
   parameter int HALF_1       = CAS_HALF_1,
   parameter int LONG_LEADER  = 16000,
   parameter int SHORT_LEADER = 4000
) (
   input  logic       clk21m,
   input  logic       reset_n,
   input  logic       ce_3m58_p,
   input  logic       cas_motor,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   input  logic [1:0] byte_leader,
`ifdef CAS_TURBO_EN
   input  logic       turbo,
`endif
   output logic       byte_ready,
   output logic       cas_audio_out,
   output logic       busy
);

   localparam logic [10:0] H0      = 11'(HALF_0);
   localparam logic [10:0] H1      = 11'(HALF_1);
   localparam logic [15:0] LONG_H  = 16'(2 * LONG_LEADER);
   localparam logic [15:0] SHORT_H = 16'(2 * SHORT_LEADER);

   cas_state_t  state, state_nxt;
   logic [15:0] half_cnt, half_cnt_nxt;
   logic [3:0]  bit_idx, bit_idx_nxt;
   cas_req_t    req_q;
   logic        accept, half_done, tone_lvl, cur_bit, seg_last;
   logic [10:0] base_len, half_len;
   logic [15:0] seg_halves;
`ifdef CAS_TURBO_EN
   logic        turbo_q;
`endif

   assign byte_ready    = (state == IDLE) & cas_motor;
   assign accept        = byte_valid & byte_ready;
   assign busy          = state != IDLE;
   assign cas_audio_out = tone_lvl & busy & cas_motor;

   always_comb begin
      cur_bit = 1'b1;
      case (state)
         START:   cur_bit = 1'b0;
         DATA:    cur_bit = req_q.data[bit_idx[2:0]];
         default: cur_bit = 1'b1;
      endcase
   end

   always_comb begin
      base_len   = (state == LEADER || cur_bit) ? H1 : H0;
      seg_halves = cur_bit ? 16'd4 : 16'd2;
      if (state == LEADER)
         seg_halves = req_q.leader[1] ? LONG_H : SHORT_H;
`ifdef CAS_TURBO_EN
      half_len = turbo_q ? (base_len >> 1) : base_len;
`else
      half_len = base_len;
`endif
   end

   assign seg_last = half_cnt == (seg_halves - 16'd1);

   always_comb begin
      state_nxt    = state;
      half_cnt_nxt = half_cnt;
      bit_idx_nxt  = bit_idx;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt    = (cas_leader_t'(byte_leader) != NONE) ? LEADER : START;
               half_cnt_nxt = '0;
               bit_idx_nxt  = '0;
            end
         end
         default: begin
            if (half_done) begin
               if (!seg_last) begin
                  half_cnt_nxt = half_cnt + 16'd1;
               end else begin
                  half_cnt_nxt = '0;
                  case (state)
                     LEADER: state_nxt = START;
                     START: begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                     end
                     DATA: begin
                        if (bit_idx == 4'd7) begin
                           state_nxt   = STOP;
                           bit_idx_nxt = '0;
                        end else begin
                           bit_idx_nxt = bit_idx + 4'd1;
                        end
                     end
                     STOP: begin
                        if (bit_idx == 4'd1) begin
                           state_nxt   = IDLE;
                           bit_idx_nxt = '0;
                        end else begin
                           bit_idx_nxt = bit_idx + 4'd1;
                        end
                     end
                     default: state_nxt = IDLE;
                  endcase
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk21m) begin
      if (!reset_n) begin
         state    <= IDLE;
         half_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         state    <= state_nxt;
         half_cnt <= half_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
      end
   end

   always_ff @(posedge clk21m) begin
      if (!reset_n) begin
         req_q <= '0;
      end else if (accept) begin
         req_q <= '{data: byte_data, leader: byte_leader};
      end
   end

`ifdef CAS_TURBO_EN
   always_ff @(posedge clk21m) begin
      if (!reset_n)
         turbo_q <= 1'b0;
      else if (accept)
         turbo_q <= turbo;
   end
`endif

   // motor gates the tick so a pause freezes the count without losing a tick
   cas_tone_gen u_tone (
      .clk21m    (clk21m),
      .reset_n   (reset_n),
      .tick      (ce_3m58_p),
      .run       (cas_motor),
      .active    (busy),
      .start     (accept),
      .half_len  (half_len),
      .level     (tone_lvl),
      .half_done (half_done)
   );

endmodule

// File: tb/tb_cas_fsk_player.sv
// Scoreboard bench: stimulus queues expected half-periods, monitor measures toggles in ticks.
module tb_cas_fsk_player;

   localparam int H0 = 6;
   localparam int H1 = 3;
   localparam int SL = 2;
   localparam int LL = 4;

   logic       clk21m      = 1'b0;
   logic       reset_n     = 1'b0;
   logic       ce_3m58_p   = 1'b0;
   logic       cas_motor   = 1'b0;
   logic       byte_valid  = 1'b0;
   logic [7:0] byte_data   = 8'h00;
   logic [1:0] byte_leader = 2'b00;
   logic       byte_ready, cas_audio_out, busy;

   typedef struct {
      int len;
      bit lvl;
   } half_t;

   half_t exp_q[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    ticks  = 0;
   bit    prev_busy = 1'b0;
   bit    prev_lvl  = 1'b0;

   cas_fsk_player #(
      .HALF_0(H0), .HALF_1(H1), .LONG_LEADER(LL), .SHORT_LEADER(SL)
   ) dut (
      .clk21m        (clk21m),
      .reset_n       (reset_n),
      .ce_3m58_p     (ce_3m58_p),
      .cas_motor     (cas_motor),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_leader   (byte_leader),
`ifdef CAS_TURBO_EN
      .turbo         (1'b0),
`endif
      .byte_ready    (byte_ready),
      .cas_audio_out (cas_audio_out),
      .busy          (busy)
   );

   always #5 clk21m = ~clk21m;

   initial begin : ce_gen
      int k;
      k = 0;
      forever begin
         @(negedge clk21m);
         ce_3m58_p = (k == 5);
         k = (k == 5) ? 0 : k + 1;
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic push_half(input int len, input bit lvl);
      half_t h;
      h.len = len;
      h.lvl = lvl;
      exp_q.push_back(h);
   endtask

   task automatic push_bit(input bit v);
      if (v) for (int i = 0; i < 4; i++) push_half(H1, (i % 2) == 0);
      else   for (int i = 0; i < 2; i++) push_half(H0, (i % 2) == 0);
   endtask

   task automatic push_byte(input logic [7:0] d, input logic [1:0] l);
      int nl;
      nl = (l == 2'b00) ? 0 : (l == 2'b01) ? 2 * SL : 2 * LL;
      for (int i = 0; i < nl; i++) push_half(H1, (i % 2) == 0);
      push_bit(1'b0);
      for (int b = 0; b < 8; b++) push_bit(d[b]);
      push_bit(1'b1);
      push_bit(1'b1);
   endtask

   task automatic pop_cmp();
      half_t h;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL extra_half: got half of %0d ticks, required none at %0t", ticks, $time);
      end else begin
         h = exp_q.pop_front();
         chk("half_len", ticks, h.len);
         chk("half_lvl", {31'd0, prev_lvl}, {31'd0, h.lvl});
      end
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk21m);
         if (ce_3m58_p && cas_motor) ticks++;
         #1;
         if (!reset_n) begin
            exp_q.delete();
            ticks     = 0;
            prev_busy = 1'b0;
            prev_lvl  = 1'b0;
         end else begin
            if (!cas_motor) chk("muted", {31'd0, cas_audio_out}, 0);
            if (busy && !prev_busy) begin
               chk("start_lvl", {31'd0, cas_audio_out}, 1);
               prev_lvl = 1'b1;
               ticks    = 0;
            end else if (busy && cas_motor && (cas_audio_out != prev_lvl)) begin
               pop_cmp();
               prev_lvl = cas_audio_out;
               ticks    = 0;
            end else if (!busy && prev_busy) begin
               pop_cmp();
               chk("idle_lvl", {31'd0, cas_audio_out}, 0);
               chk("ready_after", {31'd0, byte_ready}, {31'd0, cas_motor});
               ticks = 0;
            end
            prev_busy = busy;
         end
      end
   end

   task automatic accept(input logic [7:0] d, input logic [1:0] l);
      int n;
      n = 0;
      push_byte(d, l);
      @(negedge clk21m);
      byte_valid  = 1'b1;
      byte_data   = d;
      byte_leader = l;
      while (!byte_ready && n < 2000) begin
         @(negedge clk21m);
         n++;
      end
      chk("accept_wait", (n < 2000), 1);
      @(posedge clk21m);
      #1;
      chk("first_out", {30'd0, busy, cas_audio_out}, 3);
      @(negedge clk21m);
      byte_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 5000) begin
         @(negedge clk21m);
         n++;
      end
      chk("idle_wait", (n < 5000), 1);
   endtask

   initial begin : stim
      int n;
      cas_motor = 1'b1;
      repeat (5) @(negedge clk21m);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_out", {31'd0, cas_audio_out}, 0);
      chk("rst_ready_on", {31'd0, byte_ready}, 1);
      cas_motor = 1'b0;
      #1;
      chk("rst_ready_off", {31'd0, byte_ready}, 0);
      @(negedge clk21m);
      cas_motor = 1'b1;
      reset_n   = 1'b1;

      // back-to-back: second byte offered while the first is still busy
      accept(8'hA5, 2'b00);
      accept(8'h00, 2'b01);
      wait_idle();
      @(negedge clk21m);
      chk("idle_after_short", {31'd0, cas_audio_out}, 0);

      accept(8'h3C, 2'b10);
      wait_idle();

      // motor pause mid-DATA
      accept(8'hC3, 2'b00);
      repeat (100) @(negedge clk21m);
      cas_motor = 1'b0;
      repeat (50) @(negedge clk21m);
      chk("pause_busy", {31'd0, busy}, 1);
      cas_motor = 1'b1;
      wait_idle();

      // valid held while motor off
      push_byte(8'h81, 2'b01);
      @(negedge clk21m);
      cas_motor   = 1'b0;
      byte_valid  = 1'b1;
      byte_data   = 8'h81;
      byte_leader = 2'b01;
      repeat (20) begin
         @(negedge clk21m);
         chk("ready_motor_off", {31'd0, byte_ready}, 0);
         chk("busy_motor_off", {31'd0, busy}, 0);
      end
      cas_motor = 1'b1;
      #1;
      chk("ready_motor_on", {31'd0, byte_ready}, 1);
      @(posedge clk21m);
      #1;
      chk("accept_same_cycle", {30'd0, busy, cas_audio_out}, 3);
      @(negedge clk21m);
      byte_valid = 1'b0;
      wait_idle();

      // reset during STOP
      accept(8'hFF, 2'b00);
      n = 0;
      while (exp_q.size() > 5 && n < 5000) begin
         @(negedge clk21m);
         n++;
      end
      chk("reach_stop", (n < 5000), 1);
      reset_n = 1'b0;
      @(posedge clk21m);
      #1;
      chk("rst_mid_busy", {31'd0, busy}, 0);
      chk("rst_mid_out", {31'd0, cas_audio_out}, 0);
      @(negedge clk21m);
      reset_n = 1'b1;

      accept(8'h5A, 2'b11);
      wait_idle();

      repeat (10) @(negedge clk21m);
      chk("queue_empty", exp_q.size(), 0);
      chk("final_out", {31'd0, cas_audio_out}, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
